// File: rtl/drive_pkg.sv
// Shared types and helpers for the drive mixer: mode encoding, the
// offset-binary centre code and the clamp used by the mixer.
package drive_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TRACK = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int MODE_W = 2;

  // Centre of an offset-binary field: 2^(w-1)-1, so 31 for a 6-bit field.
  function automatic int center_code(input int in_w);
    return (1 << (in_w - 1)) - 1;
  endfunction

  function automatic int saturate(input int value, input int hi);
    if (value < 0) return 0;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/speed_ramp.sv
// One channel of the slew limiter: on a tick, move current toward target by
// at most step, never overshooting.
module speed_ramp #(
  parameter int SPD_W = 8
) (
  input  logic [SPD_W-1:0] target,
  input  logic [SPD_W-1:0] current,
  input  logic             tick,
  input  logic [SPD_W-1:0] step,
  output logic [SPD_W-1:0] next_current
);

  logic             rising;
  logic [SPD_W-1:0] diff;
  logic [SPD_W-1:0] delta;

  always_comb begin
    rising       = (target >= current);
    diff         = rising ? (target - current) : (current - target);
    delta        = (diff < step) ? diff : step;
    next_current = current;
    if (tick) next_current = rising ? (current + delta) : (current - delta);
  end

endmodule

// File: rtl/drive_mixer.sv
// Differential drive mixer: x/y command to left/right servo speed codes with
// saturation, slew ramping, a command watchdog and an OFF/DRIVE/TRACK/FAULT mode.
module drive_mixer
  import drive_pkg::*;
#(
  parameter int IN_W        = 6,
  parameter int SPD_W       = 8,
  parameter int NEUTRAL     = 128,
  parameter int Y_GAIN      = 4,
  parameter int X_GAIN      = 1,
  parameter int RAMP_STEP   = 4,
  parameter int RAMP_DIV    = 1000,
  parameter int WDOG_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              power,
  input  logic              image_mode,
  input  logic              cmd_valid,
  input  logic [IN_W-1:0]   cmd_x,
  input  logic [IN_W-1:0]   cmd_y,
  output logic [SPD_W-1:0]  speed_0,
  output logic [SPD_W-1:0]  speed_1,
  output logic              write_en_0,
  output logic              write_en_1,
  output logic [2:0]        step_0,
  output logic [2:0]        step_1,
  output logic [MODE_W-1:0] mode
);

  localparam int CENTER     = center_code(IN_W);
  localparam int MIX_W      = SPD_W + IN_W + 4;
  localparam int SPD_MAX    = (1 << SPD_W) - 1;
  localparam int STEP_CLAMP = (RAMP_STEP > SPD_MAX) ? SPD_MAX : RAMP_STEP;
  localparam int PRE_W      = $clog2(RAMP_DIV + 1);
  localparam int WD_W       = $clog2(WDOG_CYCLES + 1);

  state_t                   state_reg, state_next;
  logic [PRE_W-1:0]         presc_reg;
  logic [WD_W-1:0]          wdog_reg;
  logic                     tick, wdog_expire;
  logic                     write_en_reg;
  logic [2:0]               step_0_reg, step_1_reg;
  logic signed [MIX_W-1:0]  x_off, y_off;
  logic signed [MIX_W-1:0]  mix [2];
  logic [SPD_W-1:0]         mix_sat [2];
  logic [SPD_W-1:0]         target_reg [2];
  logic [SPD_W-1:0]         speed_reg [2];
  logic [SPD_W-1:0]         ramp_next [2];

  assign tick        = (presc_reg == PRE_W'(RAMP_DIV - 1));
  assign wdog_expire = (state_reg == ST_DRIVE) && (wdog_reg == WD_W'(WDOG_CYCLES - 1));

  assign x_off  = $signed(MIX_W'(cmd_x)) - MIX_W'(CENTER);
  assign y_off  = $signed(MIX_W'(cmd_y)) - MIX_W'(CENTER);
  assign mix[0] = MIX_W'(NEUTRAL) + MIX_W'(Y_GAIN) * y_off + MIX_W'(X_GAIN) * x_off;
  assign mix[1] = MIX_W'(NEUTRAL) + MIX_W'(Y_GAIN) * y_off - MIX_W'(X_GAIN) * x_off;

  // A fresh command always beats a watchdog expiry and is the only way out of FAULT.
  always_comb begin
    state_next = ST_DRIVE;
    if (!power)                                        state_next = ST_OFF;
    else if (image_mode)                               state_next = ST_TRACK;
    else if (cmd_valid)                                state_next = ST_DRIVE;
    else if ((state_reg == ST_FAULT) || wdog_expire)   state_next = ST_FAULT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_OFF;
      presc_reg    <= '0;
      wdog_reg     <= '0;
      write_en_reg <= 1'b1;
      step_0_reg   <= '0;
      step_1_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      presc_reg    <= tick ? '0 : presc_reg + 1'b1;
      wdog_reg     <= ((state_reg == ST_DRIVE) && (state_next == ST_DRIVE) && !cmd_valid)
                      ? wdog_reg + 1'b1 : '0;
      write_en_reg <= (state_next != ST_TRACK);
      if (state_next != ST_TRACK) begin
        step_0_reg <= '0;
        step_1_reg <= '0;
      end else if (cmd_valid && (cmd_x != '0)) begin
        step_0_reg <= cmd_x[IN_W-1 -: 3];
        step_1_reg <= 3'd7 - cmd_x[IN_W-1 -: 3];
      end
    end
  end

  // Targets sit at neutral outside DRIVE so a later DRIVE entry starts from rest.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    assign mix_sat[gi] = SPD_W'(saturate(int'(mix[gi]), SPD_MAX));

    speed_ramp #(.SPD_W(SPD_W)) u_ramp (
      .target       (target_reg[gi]),
      .current      (speed_reg[gi]),
      .tick         (tick),
      .step         (SPD_W'(STEP_CLAMP)),
      .next_current (ramp_next[gi])
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        target_reg[gi] <= SPD_W'(NEUTRAL);
        speed_reg[gi]  <= SPD_W'(NEUTRAL);
      end else begin
        if (state_next != ST_DRIVE)
          target_reg[gi] <= SPD_W'(NEUTRAL);
        else if (cmd_valid)
          target_reg[gi] <= mix_sat[gi];
        if ((state_next == ST_OFF) || (state_next == ST_TRACK))
          speed_reg[gi] <= SPD_W'(NEUTRAL);
        else
          speed_reg[gi] <= ramp_next[gi];
      end
    end
  end

  assign speed_0    = speed_reg[0];
  assign speed_1    = speed_reg[1];
  assign write_en_0 = write_en_reg;
  assign write_en_1 = write_en_reg;
  assign step_0     = step_0_reg;
  assign step_1     = step_1_reg;
  assign mode       = state_reg;

endmodule

// File: tb/tb_drive_mixer.sv
// Scoreboard bench for drive_mixer: a behavioural model predicts every cycle's
// outputs into a queue that an independent monitor drains and compares.
module tb_drive_mixer;

  localparam int RDIV  = 4;
  localparam int RSTEP = 4;
  localparam int WDOG  = 100;
  localparam int CTR   = 31;
  localparam int NEU   = 128;

  logic       clk = 1'b0;
  logic       reset = 1'b1, power = 1'b0, image_mode = 1'b0, cmd_valid = 1'b0;
  logic [5:0] cmd_x = '0, cmd_y = '0;
  logic [7:0] speed_0, speed_1;
  logic       write_en_0, write_en_1;
  logic [2:0] step_0, step_1;
  logic [1:0] mode;

  drive_mixer #(
    .IN_W(6), .SPD_W(8), .NEUTRAL(NEU), .Y_GAIN(4), .X_GAIN(1),
    .RAMP_STEP(RSTEP), .RAMP_DIV(RDIV), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .reset(reset), .power(power), .image_mode(image_mode),
    .cmd_valid(cmd_valid), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .speed_0(speed_0), .speed_1(speed_1),
    .write_en_0(write_en_0), .write_en_1(write_en_1),
    .step_0(step_0), .step_1(step_1), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] s0, s1;
    logic       we;
    logic [2:0] st0, st1;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state (modes: 0 off, 1 drive, 2 track, 3 fault)
  int m_mode, m_pre, m_wd, m_we, m_st0, m_st1;
  int m_tgt[2];
  int m_spd[2];

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic void model_step(input bit rst, pw, img, cv, input int x, y);
    int nxt;
    bit tk;
    if (rst) begin
      m_mode = 0; m_pre = 0; m_wd = 0; m_we = 1; m_st0 = 0; m_st1 = 0;
      m_tgt[0] = NEU; m_tgt[1] = NEU; m_spd[0] = NEU; m_spd[1] = NEU;
      return;
    end
    if (!pw)                                      nxt = 0;
    else if (img)                                 nxt = 2;
    else if (cv)                                  nxt = 1;
    else if (m_mode == 3)                         nxt = 3;
    else if (m_mode == 1 && m_wd == WDOG - 1)     nxt = 3;
    else                                          nxt = 1;
    tk = (m_pre == RDIV - 1);
    m_pre = (m_pre + 1) % RDIV;
    for (int c = 0; c < 2; c++) begin
      if (nxt == 0 || nxt == 2) m_spd[c] = NEU;
      else if (tk) m_spd[c] += clampi(m_tgt[c] - m_spd[c], -RSTEP, RSTEP);
      if (nxt != 1) m_tgt[c] = NEU;
      else if (cv)
        m_tgt[c] = clampi(NEU + 4 * (y - CTR) + (c == 0 ? 1 : -1) * (x - CTR), 0, 255);
    end
    m_wd = (m_mode == 1 && nxt == 1 && !cv) ? m_wd + 1 : 0;
    if (nxt != 2) begin
      m_st0 = 0; m_st1 = 0;
    end else if (cv && x != 0) begin
      m_st0 = x / 8; m_st1 = 7 - m_st0;
    end
    m_we = (nxt != 2) ? 1 : 0;
    m_mode = nxt;
  endfunction

  task automatic step_in(input bit rst, pw, img, cv, input int x, input int y);
    exp_t e;
    reset = rst; power = pw; image_mode = img; cmd_valid = cv;
    cmd_x = 6'(x); cmd_y = 6'(y);
    model_step(rst, pw, img, cv, x, y);
    e.mode = 2'(m_mode); e.s0 = 8'(m_spd[0]); e.s1 = 8'(m_spd[1]);
    e.we = 1'(m_we); e.st0 = 3'(m_st0); e.st1 = 3'(m_st1);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit img = 1'b0);
    for (int i = 0; i < n; i++) step_in(1'b0, 1'b1, img, 1'b0, 0, 0);
  endtask

  task automatic hold_cmd(input int x, input int y, input int reps);
    for (int r = 0; r < reps; r++) begin
      step_in(1'b0, 1'b1, 1'b0, 1'b1, x, y);
      idle(9);
    end
  endtask

  task automatic spot(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: the DUT presents a new output set after every active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (mode !== e.mode || speed_0 !== e.s0 || speed_1 !== e.s1 ||
            write_en_0 !== e.we || write_en_1 !== e.we ||
            step_0 !== e.st0 || step_1 !== e.st1) begin
          miscompares++;
          $display("FAIL vec %0d @%0t: mode=%0d spd=%0d/%0d we=%0b/%0b step=%0d/%0d, expected mode=%0d spd=%0d/%0d we=%0b step=%0d/%0d",
                   vectors, $time, mode, speed_0, speed_1, write_en_0, write_en_1, step_0, step_1,
                   e.mode, e.s0, e.s1, e.we, e.st0, e.st1);
        end
      end
    end
  end

  initial begin
    int rate;
    bit img_ph, rst, pw, cv;
    int x, y;

    for (int i = 0; i < 3; i++) step_in(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    spot("reset_mode", mode, 0);
    spot("reset_speed0", speed_0, NEU);
    spot("reset_we", write_en_0, 1);

    step_in(1'b0, 1'b1, 1'b0, 1'b1, 31, 31);
    idle(4);
    spot("centre_mode", mode, 1);
    spot("centre_speed1", speed_1, NEU);

    hold_cmd(31, 56, 12);
    spot("climb_speed0", speed_0, 228);
    spot("climb_speed1", speed_1, 228);

    hold_cmd(63, 63, 10);
    spot("sat_hi_speed0", speed_0, 255);
    spot("sat_hi_speed1", speed_1, 224);
    hold_cmd(0, 0, 30);
    spot("sat_lo_speed0", speed_0, 0);
    spot("sat_lo_speed1", speed_1, 35);

    hold_cmd(31, 56, 30);
    idle(100);
    spot("wdog_mode", mode, 3);
    idle(150);
    spot("wdog_speed0", speed_0, NEU);
    step_in(1'b0, 1'b1, 1'b0, 1'b1, 31, 31);
    spot("wdog_exit_mode", mode, 1);

    step_in(1'b0, 1'b1, 1'b1, 1'b1, 45, 31);
    spot("track_we", write_en_0, 0);
    spot("track_step0", step_0, 5);
    spot("track_step1", step_1, 2);
    step_in(1'b0, 1'b1, 1'b1, 1'b1, 0, 31);
    idle(3, 1'b1);
    spot("track_hold_step0", step_0, 5);
    spot("track_hold_step1", step_1, 2);

    hold_cmd(31, 56, 7);
    step_in(1'b0, 1'b0, 1'b0, 1'b1, 63, 63);
    spot("off_mode", mode, 0);
    spot("off_speed0", speed_0, NEU);
    spot("off_step0", step_0, 0);
    idle(8);
    spot("off_discard_speed0", speed_0, NEU);

    for (int ph = 0; ph < 12; ph++) begin
      case ($urandom_range(0, 2))
        0:       rate = 4;
        1:       rate = 64;
        default: rate = 0;
      endcase
      img_ph = (ph % 4 == 3);
      for (int i = 0; i < 200; i++) begin
        rst = ($urandom_range(0, 499) == 0);
        pw  = ($urandom_range(0, 299) != 0);
        cv  = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
        x   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 63));
        y   = int'($urandom_range(0, 63));
        step_in(rst, pw, img_ph, cv, x, y);
      end
    end

    idle(2);
    spot("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/drive_mixer.md
Name: drive_mixer

Overview:
Parametrised successor to the fixed-width robot drive block. Turns an offset-binary x/y command into left/right continuous-servo speed codes for the servo control module. Adds saturating arithmetic, slew-rate ramping, a command watchdog, and an explicit mode state machine. Sits between the command source (joystick/image tracker) and the servo control module.

Parameters:
IN_W, 6, command field width; centre code CENTER = 2^(IN_W-1)-1
SPD_W, 8, servo speed code width
NEUTRAL, 128, stop speed code
Y_GAIN, 4, forward gain
X_GAIN, 1, turn gain
RAMP_STEP, 4, maximum speed change per ramp tick
RAMP_DIV, 1000, clocks per ramp tick (≥1)
WDOG_CYCLES, 50000000, clocks without cmd_valid before FAULT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
power  in  1  0 forces stop
image_mode  in  1  1 selects TRACK mode
cmd_valid  in  1  one-cycle strobe; cmd_x/cmd_y valid
cmd_x  in  IN_W  turn / object x position, offset-binary
cmd_y  in  IN_W  forward command, offset-binary
speed_0  out  SPD_W  left servo speed code
speed_1  out  SPD_W  right servo speed code
write_en_0  out  1  speed write enable, servo 0
write_en_1  out  1  speed write enable, servo 1
step_0  out  3  increment step, servo 0
step_1  out  3  increment step, servo 1
mode  out  2  current state, for LEDs

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state OFF, speed_0/1 = NEUTRAL, write_en_0/1 = 1, step_0/1 = 0, targets = NEUTRAL, prescaler = 0, watchdog = 0.
- States, encoded on mode: OFF=0, DRIVE=1, TRACK=2, FAULT=3.
- Transition priority each cycle: reset > !power (→OFF) > image_mode (→TRACK) > watchdog expiry (→FAULT) > otherwise DRIVE.
  - FAULT is left only on cmd_valid.
  - OFF/TRACK → DRIVE starts from current = NEUTRAL.
- Mixing, signed, intermediate width SPD_W+IN_W+4:
  - x = cmd_x - CENTER, y = cmd_y - CENTER
  - t0 = NEUTRAL + Y_GAIN*y + X_GAIN*x
  - t1 = NEUTRAL + Y_GAIN*y - X_GAIN*x
  - Both saturate to [0, 2^SPD_W-1]. No wrap-around.
  - Targets register the cycle after cmd_valid.
- Ramp: free-running prescaler 0..RAMP_DIV-1; tick when the count equals RAMP_DIV-1.
  - On a tick, each current speed moves toward its target by min(RAMP_STEP, |target-current|).
  - With RAMP_DIV=1 and a large RAMP_STEP, speed changes 2 cycles after cmd_valid.
- OFF: speeds = NEUTRAL immediately (no ramp); write_en = 1; steps = 0.
- DRIVE: write_en = 1; steps hold 0; speeds follow the ramp.
- TRACK: write_en = 0; speeds held at NEUTRAL.
  - On cmd_valid with cmd_x ≠ 0: step_0 = cmd_x[IN_W-1:IN_W-3], step_1 = 7 - step_0.
  - cmd_x = 0 means no object; steps hold.
- FAULT: targets forced to NEUTRAL and speeds ramp down; write_en = 1.
- Watchdog:
  - Counts in DRIVE only; clears on cmd_valid or on any state change.
  - At WDOG_CYCLES-1 the next state is FAULT.
- Simultaneous events:
  - cmd_valid in the same cycle as power=0: command discarded.
  - cmd_valid in the same cycle as watchdog expiry: the command wins; state stays DRIVE.
- Reset mid-ramp: outputs return to reset values on the next edge.

Decomposition:
- Package drive_pkg: state enum, mode encodings, CENTER derivation, saturate function.
- Sub-module speed_ramp, instantiated per channel: target, current, tick, step → next current.

Test Plan:
- Reset, then power=1, cmd x=31 y=31 (RAMP_DIV=1, RAMP_STEP=255) -> speed_0 = speed_1 = 128 within 2 cycles; mode=1.
- cmd y=56 x=31, RAMP_DIV=4, RAMP_STEP=4 -> both speeds climb by 4 every 4 clocks; reach 228 after 25 ticks (100 clocks); never overshoot.
- Saturation: y=63 x=63 -> speed_0=255, speed_1=224; y=0 x=0 -> speed_0=0, speed_1=35.
- Watchdog with WDOG_CYCLES=100: no cmd_valid for 100 clocks -> mode=3, speeds ramp to 128; then cmd_valid -> mode=1.
- image_mode=1, cmd_x=45 -> write_en=0, step_0=5, step_1=2; then cmd_x=0 -> steps hold 5/2.
- power=0 mid-ramp at speed 200 -> next cycle speeds = 128, steps = 0, mode=0; cmd_valid in the same cycle is ignored.
